// File: rtl/bias_add_2.sv
// bias_add_2 : adds a per-channel bias to a channel-interleaved accumulator
// stream and saturates the result to the output width.
//
// Operation: after reset the block reads CH bias words into a local table
// (LOAD), then streams accumulator words through a one-entry output register,
// adding table[ch] and saturating to OUT_W (RUN). RUN lasts until the next
// reset; the bias stream is left backpressured.
//
// Ports:
//   ap_clk          clock, all state on rising edge
//   ap_rst_n        asynchronous active-low reset
//   bias_V_dout     bias word, first-word-fall-through
//   bias_V_empty_n  bias word available
//   bias_V_read     bias word consumed this cycle
//   acc_V_dout      accumulator word, channels 0..CH-1 per pixel
//   acc_V_empty_n   accumulator word available
//   acc_V_read      accumulator word consumed this cycle
//   output_V_din    biased, saturated result
//   output_V_full_n downstream can accept
//   output_V_write  result transferred this cycle

`ifndef KERN_S_K_2
`define KERN_S_K_2 4
`endif
`ifndef COEFF_WIDTH
`define COEFF_WIDTH 16
`endif

module bias_add_2 #(
  parameter int CH      = `KERN_S_K_2,
  parameter int COEFF_W = `COEFF_WIDTH,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [COEFF_W-1:0] bias_V_dout,
  input  logic               bias_V_empty_n,
  output logic               bias_V_read,
  input  logic [ACC_W-1:0]   acc_V_dout,
  input  logic               acc_V_empty_n,
  output logic               acc_V_read,
  output logic [OUT_W-1:0]   output_V_din,
  input  logic               output_V_full_n,
  output logic               output_V_write
);

  localparam int CNT_W = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CH - 1);

  // Saturation limits expressed at the widened sum width.
  localparam logic signed [ACC_W:0] SUM_MAX =
    {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SUM_MIN =
    {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_load_cnt;
  logic [CNT_W-1:0]   r_ch_cnt;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_data;
  logic [COEFF_W-1:0] r_table [CH];

  logic               w_bias_rd;
  logic               w_acc_rd;
  logic               w_out_wr;
  logic [COEFF_W-1:0] w_bias;
  logic signed [ACC_W:0] w_acc_x;
  logic signed [ACC_W:0] w_bias_x;
  logic signed [ACC_W:0] w_sum;
  logic [OUT_W-1:0]   w_sat;

  // Strobes are gated by reset so they drop the moment reset asserts,
  // independent of the upstream/downstream handshake inputs.
  assign w_bias_rd = ap_rst_n && (r_state == ST_LOAD) && bias_V_empty_n;
  assign w_out_wr  = ap_rst_n && r_out_valid && output_V_full_n;
  // A new word may enter when the output register is empty or draining now.
  assign w_acc_rd  = ap_rst_n && (r_state == ST_RUN) && acc_V_empty_n &&
                     (!r_out_valid || output_V_full_n);

  assign bias_V_read    = w_bias_rd;
  assign acc_V_read     = w_acc_rd;
  assign output_V_write = w_out_wr;
  assign output_V_din   = r_out_data;

  // Sign-extend both operands one bit past the accumulator so the add
  // cannot wrap.
  assign w_bias   = r_table[r_ch_cnt];
  assign w_acc_x  = {acc_V_dout[ACC_W-1], acc_V_dout};
  assign w_bias_x = {{(ACC_W + 1 - COEFF_W){w_bias[COEFF_W-1]}}, w_bias};
  assign w_sum    = w_acc_x + w_bias_x;

  always_comb begin
    // NOTE: default assignment first so every path drives w_sat; without it
    // the incomplete if/else would infer a latch.
    w_sat = w_sum[OUT_W-1:0];
    if (w_sum > SUM_MAX) begin
      w_sat = OUT_MAX;
    end else if (w_sum < SUM_MIN) begin
      w_sat = OUT_MIN;
    end
  end

  // NOTE: the bias table has no reset branch: it is always reloaded before
  // use, and leaving it unreset lets it map onto plain storage.
  always_ff @(posedge ap_clk) begin
    if (w_bias_rd) begin
      r_table[r_load_cnt] <= bias_V_dout;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state     <= ST_LOAD;
      r_load_cnt  <= '0;
      r_ch_cnt    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_bias_rd) begin
            if (r_load_cnt == LAST_CH) begin
              r_load_cnt <= '0;
              r_state    <= ST_RUN;
            end else begin
              r_load_cnt <= r_load_cnt + CNT_W'(1);
            end
          end
        end
        ST_RUN: begin
          // Stays here until reset; bias stream is intentionally stalled.
        end
        default: r_state <= ST_LOAD;
      endcase

      // A read refills the output register even when it drains in the same
      // cycle, giving one word per cycle.
      if (w_acc_rd) begin
        r_out_data  <= w_sat;
        r_out_valid <= 1'b1;
        if (r_ch_cnt == LAST_CH) begin
          r_ch_cnt <= '0;
        end else begin
          r_ch_cnt <= r_ch_cnt + CNT_W'(1);
        end
      end else if (w_out_wr) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bias_add_2.sv
// Self-checking bench for bias_add_2 (CH=4, COEFF_W=16, ACC_W=32, OUT_W=16).
// The reference model turns each consumed accumulator word into the expected
// output: saturate(acc + bias[k mod CH]) with k counting words since the
// last bias load, then outputs must appear in that order.

module tb_bias_add_2;

  localparam int CH      = 4;
  localparam int COEFF_W = 16;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 16;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n;
  logic [COEFF_W-1:0] bias_V_dout;
  logic               bias_V_empty_n;
  logic               bias_V_read;
  logic [ACC_W-1:0]   acc_V_dout;
  logic               acc_V_empty_n;
  logic               acc_V_read;
  logic [OUT_W-1:0]   output_V_din;
  logic               output_V_full_n;
  logic               output_V_write;

  bias_add_2 #(.CH(CH), .COEFF_W(COEFF_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .bias_V_dout     (bias_V_dout),
    .bias_V_empty_n  (bias_V_empty_n),
    .bias_V_read     (bias_V_read),
    .acc_V_dout      (acc_V_dout),
    .acc_V_empty_n   (acc_V_empty_n),
    .acc_V_read      (acc_V_read),
    .output_V_din    (output_V_din),
    .output_V_full_n (output_V_full_n),
    .output_V_write  (output_V_write)
  );

  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_bad    = 0;

  logic [15:0]        bq[$];     // bias source words
  logic signed [31:0] aq[$];     // accumulator source words
  logic [15:0]        exp_q[$];  // expected outputs, in order
  int model_bias[CH];
  int k_acc, n_bias_rd, n_out, n_pushed, n_dropped, cyc;
  int first_rd, first_wr, last_wr;
  int p_bias, p_acc, p_full;
  logic s_br, s_ar, s_ow;
  logic [15:0] s_od;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [15:0] sat16(input longint v);
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  task automatic drive();
    bias_V_empty_n  = (bq.size() > 0) && ($urandom_range(99) < p_bias);
    bias_V_dout     = (bq.size() > 0) ? bq[0] : '0;
    acc_V_empty_n   = (aq.size() > 0) && ($urandom_range(99) < p_acc);
    acc_V_dout      = (aq.size() > 0) ? aq[0] : '0;
    output_V_full_n = ($urandom_range(99) < p_full);
  endtask

  // One clock: sample strobes at the falling edge, update the model and the
  // source queues after the rising edge, then drive new inputs.
  task automatic tick();
    @(negedge ap_clk);
    s_br = bias_V_read;
    s_ar = acc_V_read;
    s_ow = output_V_write;
    s_od = output_V_din;
    if (s_ow) begin
      n_out++;
      last_wr = cyc;
      if (first_wr < 0) first_wr = cyc;
      if (exp_q.size() == 0) check("unexpected_write", 1, 0);
      else check("out_data", {16'b0, s_od}, {16'b0, exp_q.pop_front()});
    end
    if (s_br) n_bias_rd++;
    if (s_ar) begin
      if (first_rd < 0) first_rd = cyc;
      if (aq.size() == 0) check("read_while_empty", 1, 0);
      else exp_q.push_back(sat16(longint'(aq[0]) + longint'(model_bias[k_acc % CH])));
      k_acc++;
    end
    @(posedge ap_clk);
    #1;
    cyc++;
    if (s_br && bq.size() > 0) void'(bq.pop_front());
    if (s_ar && aq.size() > 0) void'(aq.pop_front());
    drive();
  endtask

  task automatic push_acc(input logic signed [31:0] v);
    aq.push_back(v);
    n_pushed++;
  endtask

  // Feeds model_bias (plus 'extra' spare words) and runs until CH reads seen;
  // no accumulator read or output write may happen meanwhile.
  task automatic load_biases(input int extra, input int pb);
    p_bias = pb;
    n_bias_rd = 0;
    k_acc = 0;
    for (int i = 0; i < CH; i++) bq.push_back(16'(model_bias[i]));
    for (int i = 0; i < extra; i++) bq.push_back(16'h5a5a + 16'(i));
    for (int i = 0; i < 400 && n_bias_rd < CH; i++) begin
      tick();
      check("load_no_acc_read", {31'b0, s_ar}, 0);
      check("load_no_write", {31'b0, s_ow}, 0);
    end
    check("load_count", n_bias_rd, CH);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (aq.size() > 0 || exp_q.size() > 0); i++) tick();
    check("drain_done", aq.size() + exp_q.size(), 0);
  endtask

  task automatic wait_read(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (s_ar) break;
    end
    check("read_seen", {31'b0, s_ar}, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    ap_rst_n = 1'b0;
    bias_V_dout = '0; acc_V_dout = '0;
    bias_V_empty_n = 1'b0; acc_V_empty_n = 1'b0; output_V_full_n = 1'b0;
    k_acc = 0; n_bias_rd = 0; n_out = 0; n_pushed = 0; n_dropped = 0; cyc = 0;
    first_rd = -1; first_wr = -1; last_wr = -1;
    p_bias = 100; p_acc = 100; p_full = 100;

    // Reset: strobes low even with every handshake input asserted.
    #2;
    bias_V_empty_n = 1'b1; acc_V_empty_n = 1'b1; output_V_full_n = 1'b1;
    #10;
    check("rst_bias_read", {31'b0, bias_V_read}, 0);
    check("rst_acc_read", {31'b0, acc_V_read}, 0);
    check("rst_write", {31'b0, output_V_write}, 0);
    check("rst_din", {16'b0, output_V_din}, 0);
    bias_V_empty_n = 1'b0; acc_V_empty_n = 1'b0; output_V_full_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Load 10,-5,0,7 with spare bias words always offered; accs waiting.
    model_bias = '{10, -5, 0, 7};
    push_acc(100); push_acc(100); push_acc(100); push_acc(100);
    push_acc(1); push_acc(1);
    load_biases(2, 100);
    drain(50);
    check("first_latency", first_wr - first_rd, 1);
    check("burst_spacing", last_wr - first_wr, 5);
    check("bias_reads_after_load", n_bias_rd, CH);

    // Saturation, including exact boundaries (k continues at ch2).
    push_acc(7); push_acc(8);
    push_acc(40000); push_acc(-40000); push_acc(0); push_acc(0);
    push_acc(32757); push_acc(-32763); push_acc(0); push_acc(0);
    push_acc(32758); push_acc(-32764); push_acc(0); push_acc(0);
    push_acc(32756);
    drain(60);

    // Stall: output held, no acc reads for 5 cycles, then release.
    p_full = 0;
    push_acc(5); push_acc(6); push_acc(7);
    wait_read(20);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_no_read", {31'b0, s_ar}, 0);
      check("stall_no_write", {31'b0, s_ow}, 0);
      check("stall_din", {16'b0, s_od}, {16'b0, exp_q[0]});
    end
    p_full = 100;
    drain(30);

    // Random handshakes over 1000 words.
    p_acc = 60; p_full = 60;
    for (int i = 0; i < 1000; i++) begin
      logic signed [31:0] v;
      if ($urandom_range(3) == 0) v = $urandom;
      else v = int'($urandom_range(80000)) - 40000;
      push_acc(v);
    end
    drain(8000);
    check("bias_reads_in_run", n_bias_rd, CH);

    // Align to pixel start, emit 2 outputs, then reset with a word pending.
    p_acc = 100; p_full = 100;
    while (((k_acc + aq.size()) % CH) != 0) push_acc(0);
    drain(20);
    push_acc(300); push_acc(301);
    drain(20);
    p_full = 0;
    push_acc(302);
    wait_read(20);
    tick();
    output_V_full_n = 1'b1;
    #1;
    check("pending_before_reset", {31'b0, output_V_write}, 1);
    ap_rst_n = 1'b0;
    #1;
    check("reset_drops_write", {31'b0, output_V_write}, 0);
    check("reset_acc_read", {31'b0, acc_V_read}, 0);
    check("reset_bias_read", {31'b0, bias_V_read}, 0);
    n_dropped += exp_q.size();
    exp_q.delete(); aq.delete(); bq.delete();
    drive();
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Reload with fresh biases; the next acc must use the new ch0 bias.
    p_full = 100;
    model_bias = '{1, 2, 3, 4};
    push_acc(50); push_acc(-60);
    load_biases(0, 50);
    drain(40);

    for (int i = 0; i < 5; i++) tick();
    check("output_count", n_out, n_pushed - n_dropped);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
